// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM (1-cycle read latency).
// One access is forwarded per cycle; a losing or blocked strobe waits in a one-deep slot.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter bit RR_INIT    = 1'b0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wmask,
  input  logic                  m0_rstrb,
  output logic [31:0]           m0_rdata,
  output logic                  m0_rbusy,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wmask,
  input  logic                  m1_rstrb,
  output logic [31:0]           m1_rdata,
  output logic                  m1_rbusy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            ram_wmask,
  output logic                  ram_rstrb,
  input  logic [31:0]           ram_rdata,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + CNT_WIDTH'(1);
  endfunction

  logic                  acc0, acc1;
  logic                  pend_vld_p1, pend_owner_p1;
  logic [ADDR_WIDTH-1:0] pend_addr_p1;
  logic [31:0]           pend_wdata_p1;
  logic [3:0]            pend_wmask_p1;
  logic                  pend_rstrb_p1;
  logic                  rr_ptr;
  logic                  resp0_p1, resp1_p1;
  logic [31:0]           hold0, hold1;

  logic                  iss_vld, iss_owner, iss_rstrb;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic [31:0]           iss_wdata;
  logic [3:0]            iss_wmask;
  logic                  park, park_owner, rr_flip;
  logic [ADDR_WIDTH-1:0] park_addr;
  logic [31:0]           park_wdata;
  logic [3:0]            park_wmask;
  logic                  park_rstrb;

  // A strobe from a port that is already stalled is a protocol violation and is dropped.
  assign acc0 = (m0_rstrb | (|m0_wmask)) & ~m0_rbusy & reset_n;
  assign acc1 = (m1_rstrb | (|m1_wmask)) & ~m1_rbusy & reset_n;

  always_comb begin
    iss_vld    = 1'b0;
    iss_owner  = 1'b0;
    iss_addr   = m0_addr;
    iss_wdata  = m0_wdata;
    iss_wmask  = 4'b0000;
    iss_rstrb  = 1'b0;
    park       = 1'b0;
    park_owner = 1'b0;
    rr_flip    = 1'b0;
    if (pend_vld_p1) begin
      iss_vld   = 1'b1;
      iss_owner = pend_owner_p1;
      iss_addr  = pend_addr_p1;
      iss_wdata = pend_wdata_p1;
      iss_wmask = pend_wmask_p1;
      iss_rstrb = pend_rstrb_p1;
      // Only the non-owner can strobe here; it takes over the slot as it drains.
      if (acc0) begin
        park       = 1'b1;
        park_owner = 1'b0;
      end else if (acc1) begin
        park       = 1'b1;
        park_owner = 1'b1;
      end
    end else if (acc0 && acc1) begin
      rr_flip    = 1'b1;
      park       = 1'b1;
      park_owner = ~rr_ptr;
      iss_vld    = 1'b1;
      iss_owner  = rr_ptr;
      if (rr_ptr) begin
        iss_addr  = m1_addr;
        iss_wdata = m1_wdata;
        iss_wmask = m1_wmask;
        iss_rstrb = m1_rstrb;
      end else begin
        iss_wmask = m0_wmask;
        iss_rstrb = m0_rstrb;
      end
    end else if (acc0) begin
      iss_vld   = 1'b1;
      iss_wmask = m0_wmask;
      iss_rstrb = m0_rstrb;
    end else if (acc1) begin
      iss_vld   = 1'b1;
      iss_owner = 1'b1;
      iss_addr  = m1_addr;
      iss_wdata = m1_wdata;
      iss_wmask = m1_wmask;
      iss_rstrb = m1_rstrb;
    end
  end

  assign park_addr  = park_owner ? m1_addr  : m0_addr;
  assign park_wdata = park_owner ? m1_wdata : m0_wdata;
  assign park_wmask = park_owner ? m1_wmask : m0_wmask;
  assign park_rstrb = park_owner ? m1_rstrb : m0_rstrb;

  assign ram_addr  = iss_addr;
  assign ram_wdata = iss_wdata;
  assign ram_wmask = iss_wmask & {4{reset_n}};
  assign ram_rstrb = iss_rstrb & reset_n;

  // ---- issue -> slot / return stage ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld_p1   <= 1'b0;
      pend_owner_p1 <= 1'b0;
      rr_ptr        <= RR_INIT;
      resp0_p1      <= 1'b0;
      resp1_p1      <= 1'b0;
      hold0         <= 32'd0;
      hold1         <= 32'd0;
      stall_count   <= '0;
    end else begin
      pend_vld_p1 <= park;
      if (park) pend_owner_p1 <= park_owner;
      if (rr_flip) rr_ptr <= ~rr_ptr;
      resp0_p1 <= iss_vld & iss_rstrb & ~iss_owner;
      resp1_p1 <= iss_vld & iss_rstrb & iss_owner;
      if (resp0_p1) hold0 <= ram_rdata;
      if (resp1_p1) hold1 <= ram_rdata;
      if (m0_rbusy | m1_rbusy) stall_count <= sat_inc(stall_count);
    end
  end

  always_ff @(posedge clk) begin
    if (park) begin
      pend_addr_p1  <= park_addr;
      pend_wdata_p1 <= park_wdata;
      pend_wmask_p1 <= park_wmask;
      pend_rstrb_p1 <= park_rstrb;
    end
  end

  assign m0_rbusy = pend_vld_p1 & ~pend_owner_p1;
  assign m1_rbusy = pend_vld_p1 & pend_owner_p1;
  assign m0_rdata = resp0_p1 ? ram_rdata : hold0;
  assign m1_rdata = resp1_p1 ? ram_rdata : hold1;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level reference model
// (request queue, round-robin integer, shadow memory) plus directed scenarios.
module tb_mem_bus_arbiter;

  localparam int CW = 10;
  localparam int SAT = (1 << CW) - 1;

  typedef struct packed {
    logic        owner;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
  } req_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]    m0_wmask = '0, m1_wmask = '0;
  logic          m0_rstrb = 1'b0, m1_rstrb = 1'b0;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          m0_rbusy, m1_rbusy;
  logic [31:0]   ram_addr, ram_wdata;
  logic [3:0]    ram_wmask;
  logic          ram_rstrb;
  logic [31:0]   ram_rdata;
  logic [CW-1:0] stall_count;

  mem_bus_arbiter #(.ADDR_WIDTH(32), .RR_INIT(1'b0), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rstrb(ram_rstrb),
    .ram_rdata(ram_rdata), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i * 32'h0000_0101);
  endfunction

  // Synchronous RAM: read returns the word as it was before a same-cycle write.
  logic [31:0] mem [0:63];
  bit          ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      ram_rdata     <= 32'd0;
      ram_init_done <= 1'b1;
    end else begin
      if (ram_rstrb) ram_rdata <= mem[ram_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (ram_wmask[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  req_t        q[$];
  int          rr;
  bit          rv[2];
  logic [31:0] rdat[2];
  logic [31:0] hold[2];
  int          stall;
  logic [31:0] ref_mem[64];

  function automatic req_t mk(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] wm, input logic rs);
    req_t r;
    r.owner = 1'b0; r.addr = a; r.wdata = d; r.wmask = wm; r.rstrb = rs;
    return r;
  endfunction

  function automatic req_t idle();
    return mk($urandom, $urandom, 4'b0000, 1'b0);
  endfunction

  function automatic req_t rd(input logic [31:0] a);
    return mk(a, $urandom, 4'b0000, 1'b1);
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    int   k;
    k = $urandom_range(0, 9);
    r = mk(32'($urandom_range(0, 15)) << 2, $urandom, 4'b0000, 1'b0);
    if (k < 3) r.rstrb = 1'b1;
    else if (k < 5) r.wmask = 4'($urandom_range(1, 15));
    else if (k == 5) begin
      r.rstrb = 1'b1;
      r.wmask = 4'($urandom_range(1, 15));
    end
    return r;
  endfunction

  function automatic bit is_req(input req_t r);
    return r.rstrb || (r.wmask != 4'b0000);
  endfunction

  task automatic model_reset();
    q.delete();
    rr = 0;
    stall = 0;
    for (int p = 0; p < 2; p++) begin
      rv[p] = 1'b0; rdat[p] = 32'd0; hold[p] = 32'd0;
    end
  endtask

  // One clock cycle: drive, predict, compare at the falling edge, then advance the model.
  task automatic step(input bit rst, input req_t r0_in, input req_t r1_in);
    req_t r0, r1, iss;
    bit   have, b0, b1, n0, n1;
    r0 = r0_in; r0.owner = 1'b0;
    r1 = r1_in; r1.owner = 1'b1;
    @(posedge clk); #1;
    reset_n  = !rst;
    m0_addr  = r0.addr; m0_wdata = r0.wdata; m0_wmask = r0.wmask; m0_rstrb = r0.rstrb;
    m1_addr  = r1.addr; m1_wdata = r1.wdata; m1_wmask = r1.wmask; m1_rstrb = r1.rstrb;
    if (rst) model_reset();
    b0 = (q.size() > 0) && (q[0].owner == 1'b0);
    b1 = (q.size() > 0) && (q[0].owner == 1'b1);
    have = 1'b0;
    iss = r0;
    if (!rst) begin
      n0 = is_req(r0) && !b0;
      n1 = is_req(r1) && !b1;
      if (q.size() > 0) begin
        iss = q.pop_front(); have = 1'b1;
        if (n0) q.push_back(r0);
        if (n1) q.push_back(r1);
      end else if (n0 && n1) begin
        have = 1'b1;
        if (rr == 0) begin iss = r0; q.push_back(r1); end
        else begin iss = r1; q.push_back(r0); end
        rr = 1 - rr;
      end else if (n0) begin
        iss = r0; have = 1'b1;
      end else if (n1) begin
        iss = r1; have = 1'b1;
      end
    end
    @(negedge clk);
    chk("ram_rstrb", ram_rstrb, have ? iss.rstrb : 1'b0);
    chk("ram_wmask", ram_wmask, have ? iss.wmask : 4'b0000);
    chk("ram_addr", ram_addr, have ? iss.addr : r0.addr);
    chk("ram_wdata", ram_wdata, have ? iss.wdata : r0.wdata);
    chk("m0_rbusy", m0_rbusy, b0);
    chk("m1_rbusy", m1_rbusy, b1);
    chk("m0_rdata", m0_rdata, rv[0] ? rdat[0] : hold[0]);
    chk("m1_rdata", m1_rdata, rv[1] ? rdat[1] : hold[1]);
    chk("stall_count", stall_count, 64'(stall));
    if (!rst) begin
      if ((b0 || b1) && stall < SAT) stall++;
      for (int p = 0; p < 2; p++)
        if (rv[p]) begin hold[p] = rdat[p]; rv[p] = 1'b0; end
      if (have) begin
        if (iss.rstrb) begin
          rv[iss.owner] = 1'b1;
          rdat[iss.owner] = ref_mem[iss.addr[7:2]];
        end
        for (int b = 0; b < 4; b++)
          if (iss.wmask[b]) ref_mem[iss.addr[7:2]][8*b +: 8] = iss.wdata[8*b +: 8];
      end
    end
  endtask

  initial begin
    logic [31:0] old8;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    model_reset();
    repeat (3) step(1'b1, idle(), idle());

    // Uncontended read, then held
    step(1'b0, rd(32'h10), idle());
    repeat (4) step(1'b0, idle(), idle());
    chk("t1_hold", m0_rdata, init_word(4));

    // Tie with rr_ptr at reset value, then repeated tie with the pointer flipped
    step(1'b0, rd(32'h20), rd(32'h40));
    repeat (3) step(1'b0, idle(), idle());
    chk("t2_m1_data", m1_rdata, init_word(16));
    chk("t2_m0_data", m0_rdata, init_word(8));
    step(1'b0, rd(32'h24), rd(32'h44));
    repeat (3) step(1'b0, idle(), idle());

    // Pending read of 0x8 drains before the colliding partial write
    old8 = ref_mem[2];
    step(1'b0, rd(32'h30), rd(32'h8));
    step(1'b0, mk(32'h8, 32'hDEADBEEF, 4'b0011, 1'b0), idle());
    step(1'b0, idle(), idle());
    step(1'b0, idle(), idle());
    chk("t4_old_word", m1_rdata, old8);
    step(1'b0, idle(), rd(32'h8));
    step(1'b0, idle(), idle());
    chk("t4_merge", m1_rdata, {old8[31:16], 16'hBEEF});

    // Reset in the middle of a pending access
    step(1'b0, rd(32'h14), rd(32'h18));
    step(1'b1, rd(32'h1C), idle());
    step(1'b1, idle(), rd(32'h1C));
    step(1'b0, idle(), rd(32'h28));
    step(1'b0, idle(), idle());
    chk("t5_after_rst", m1_rdata, ref_mem[10]);

    // Randomized traffic with protocol violations and occasional resets
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) == 0) step(1'b1, rnd_req(), rnd_req());
      else step(1'b0, rnd_req(), rnd_req());
    end

    // Continuous contention drives the stall counter into saturation
    step(1'b1, idle(), idle());
    for (int c = 0; c < SAT + 80; c++)
      step(1'b0, rd(32'($urandom_range(0, 15)) << 2), rd(32'($urandom_range(0, 15)) << 2));
    chk("t6_sat", stall_count, 64'(SAT));
    repeat (5) step(1'b0, rd(32'h4), rd(32'h8));
    chk("t6_no_wrap", stall_count, 64'(SAT));
    repeat (3) step(1'b0, idle(), idle());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
